// File: rtl/lane_serializer_if.sv
// Parallel-in / serial-out handshake bundle for lane_serializer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface lane_serializer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              msb_first_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic [LANES-1:0]  ser_data_o;
  logic [LANES-1:0]  ser_mask_o;
  logic              ser_data_val_o;
  logic              ser_rdy_i;
  logic              ser_last_o;
  logic              busy_o;
  logic              drop_o;

  modport slave (
    input  data_i, data_mod_i, msb_first_i, data_val_i, ser_rdy_i,
    output data_rdy_o, ser_data_o, ser_mask_o, ser_data_val_o, ser_last_o, busy_o, drop_o
  );

  modport master (
    output data_i, data_mod_i, msb_first_i, data_val_i, ser_rdy_i,
    input  data_rdy_o, ser_data_o, ser_mask_o, ser_data_val_o, ser_last_o, busy_o, drop_o
  );
endinterface

// File: rtl/lane_serializer.sv
// Serializes variable-length parallel words into LANES-wide beats, with one skid-buffer entry
// behind the shifter so a following word streams out with no bubble.
module lane_serializer #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 1,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 3
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  lane_serializer_if.slave bus
);

  localparam int BEATS = DATA_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEN_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  buf_len_q, buf_len_d;
  logic              buf_full_q, buf_full_d;
  logic              drop_q, drop_d;
  logic              rdy_en_q;

  logic [MOD_W-1:0]  mod_w;
  logic [DATA_W-1:0] word_norm;
  logic [LEN_W-1:0]  len_in;
  logic              long_in;
  logic [LANES-1:0]  mask;
  logic              last;
  logic              data_rdy, accept, consume, fin;
  logic              load_in, load_buf, to_buf;

  assign mod_w = bus.data_mod_i;

  // Words are stored in stream order (bit 0 leaves first), so the shifter never needs to know
  // the bit order after acceptance.
  always_comb begin
    word_norm = bus.data_i;
    if (bus.msb_first_i) begin
      for (int i = 0; i < DATA_W; i++) word_norm[i] = bus.data_i[DATA_W-1-i];
    end
  end

  always_comb begin
    len_in = LEN_W'(DATA_W);
    if (mod_w != '0 && int'(mod_w) <= DATA_W) len_in = LEN_W'(mod_w);
  end

  assign long_in = int'(len_in) >= MIN_LEN;

  always_comb begin
    mask = '0;
    last = 1'b0;
    if (state_q == SHIFT) begin
      for (int j = 0; j < LANES; j++) mask[j] = (int'(beat_q) * LANES + j) < int'(len_q);
      last = (int'(beat_q) + 1) * LANES >= int'(len_q);
    end
  end

  assign data_rdy = rdy_en_q && !buf_full_q;
  assign accept   = bus.data_val_i && data_rdy;
  assign consume  = (state_q == SHIFT) && bus.ser_rdy_i;
  assign fin      = consume && last;
  assign load_in  = accept && long_in && ((state_q == IDLE) || (fin && !buf_full_q));
  assign load_buf = fin && buf_full_q;
  assign to_buf   = accept && long_in && !load_in;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    sh_d       = sh_q;
    len_d      = len_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    buf_len_d  = buf_len_q;
    buf_full_d = buf_full_q;
    drop_d     = 1'b0;

    if (load_in) begin
      sh_d    = word_norm;
      len_d   = len_in;
      beat_d  = '0;
      state_d = SHIFT;
    end else if (load_buf) begin
      sh_d       = buf_q;
      len_d      = buf_len_q;
      beat_d     = '0;
      buf_full_d = 1'b0;
      state_d    = SHIFT;
    end else if (consume) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        sh_d   = sh_q >> LANES;
        beat_d = beat_q + CNT_W'(1);
      end
    end

    if (to_buf) begin
      buf_d      = word_norm;
      buf_len_d  = len_in;
      buf_full_d = 1'b1;
    end

    if (accept && !long_in) drop_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the buffer word is reset too; it is tiny and keeps post-reset outputs deterministic.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      buf_q      <= '0;
      buf_len_q  <= '0;
      buf_full_q <= 1'b0;
      drop_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      buf_q      <= buf_d;
      buf_len_q  <= buf_len_d;
      buf_full_q <= buf_full_d;
      drop_q     <= drop_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign bus.data_rdy_o     = data_rdy;
  assign bus.ser_data_o     = sh_q[LANES-1:0] & mask;
  assign bus.ser_mask_o     = mask;
  assign bus.ser_data_val_o = (state_q == SHIFT);
  assign bus.ser_last_o     = last;
  assign bus.busy_o         = (state_q == SHIFT) || buf_full_q;
  assign bus.drop_o         = drop_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: a LANES=4 and a LANES=1 instance share one driver, and every
// consumed beat is scored against a bit-level model built from the word, length and order.
module tb_lane_serializer;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] m;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] drv_data = '0;
  logic [3:0]  drv_mod = '0;
  logic        drv_msb = 1'b0, drv_val = 1'b0, drv_rdy = 1'b0;
  logic        sel1 = 1'b0;

  lane_serializer_if #(.DATA_W(DATA_W), .LANES(4), .MOD_W(MOD_W)) bus4 ();
  lane_serializer_if #(.DATA_W(DATA_W), .LANES(1), .MOD_W(MOD_W)) bus1 ();

  lane_serializer #(.DATA_W(DATA_W), .LANES(4), .MOD_W(MOD_W), .MIN_LEN(MIN_LEN)) dut4 (
    .clk_i(clk), .arst_n_i(arst_n), .bus(bus4));
  lane_serializer #(.DATA_W(DATA_W), .LANES(1), .MOD_W(MOD_W), .MIN_LEN(MIN_LEN)) dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .bus(bus1));

  assign bus4.data_i = drv_data;        assign bus1.data_i = drv_data;
  assign bus4.data_mod_i = drv_mod;     assign bus1.data_mod_i = drv_mod;
  assign bus4.msb_first_i = drv_msb;    assign bus1.msb_first_i = drv_msb;
  assign bus4.data_val_i = drv_val & ~sel1;
  assign bus1.data_val_i = drv_val & sel1;
  assign bus4.ser_rdy_i = drv_rdy;      assign bus1.ser_rdy_i = drv_rdy;

  logic [3:0] o_data, o_mask;
  logic       o_val, o_last, o_rdy, o_busy, o_drop;
  assign o_data = sel1 ? {3'b000, bus1.ser_data_o} : bus4.ser_data_o;
  assign o_mask = sel1 ? {3'b000, bus1.ser_mask_o} : bus4.ser_mask_o;
  assign o_val  = sel1 ? bus1.ser_data_val_o : bus4.ser_data_val_o;
  assign o_last = sel1 ? bus1.ser_last_o : bus4.ser_last_o;
  assign o_rdy  = sel1 ? bus1.data_rdy_o : bus4.data_rdy_o;
  assign o_busy = sel1 ? bus1.busy_o : bus4.busy_o;
  assign o_drop = sel1 ? bus1.drop_o : bus4.drop_o;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, mon_cnt = 0, drop_cnt = 0, exp_drop = 0;
  beat_t exp_q[$];
  beat_t log_q[$];
  int    log_cyc[$];
  logic [15:0] ser_hist = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard and hold-while-stalled monitor, sampled mid-cycle.
  initial begin
    beat_t cur, prev_b, exp_b;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev_b = '0;
    forever begin
      @(negedge clk);
      cur = {o_data, o_mask, o_last};
      if (!arst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_tests++;
          if (!o_val || cur !== prev_b) begin
            n_fail++;
            $display("FAIL stall_hold: got val=%0b beat=%h, expected val=1 beat=%h", o_val, cur, prev_b);
          end
        end
        prev_stall = o_val && !drv_rdy;
        prev_b = cur;
        if (o_drop) drop_cnt++;
        if (o_val && drv_rdy) begin
          mon_cnt++;
          log_q.push_back(cur);
          log_cyc.push_back(cyc);
          ser_hist = {ser_hist[14:0], o_data[0]};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got beat=%h at cycle %0d, expected no beat", cur, cyc);
          end else begin
            exp_b = exp_q.pop_front();
            if (cur !== exp_b) begin
              n_fail++;
              $display("FAIL beat_value: got data=%b mask=%b last=%0b, expected data=%b mask=%b last=%0b",
                       cur.d, cur.m, cur.l, exp_b.d, exp_b.m, exp_b.l);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_lanes(input logic one_lane);
    sel1 = one_lane;
    @(posedge clk); #1;
  endtask

  // Present a word, wait for the handshake, then scramble the inputs and record expectations.
  task automatic push_word(input logic [15:0] d, input logic [3:0] m, input logic msb);
    int len, nl, nb, s;
    beat_t b;
    bit ok;
    logic r;
    drv_data = d; drv_mod = m; drv_msb = msb; drv_val = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      r = o_rdy;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    drv_val = 1'b0;
    drv_data = 16'($urandom);
    drv_mod = 4'($urandom);
    drv_msb = 1'($urandom);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: got no handshake for word %h, expected acceptance", d);
    end else begin
      len = (m == 0) ? DATA_W : int'(m);
      nl = sel1 ? 1 : 4;
      if (len < MIN_LEN) exp_drop++;
      else begin
        nb = (len + nl - 1) / nl;
        for (int bi = 0; bi < nb; bi++) begin
          b = '0;
          for (int j = 0; j < nl; j++) begin
            s = bi * nl + j;
            if (s < len) begin
              b.m[j] = 1'b1;
              b.d[j] = msb ? d[DATA_W-1-s] : d[s];
            end
          end
          b.l = (bi == nb - 1);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !o_busy) break;
      @(posedge clk); #1;
    end
    n_tests++;
    if (exp_q.size() != 0 || o_busy) begin
      n_fail++;
      $display("FAIL drain: got %0d beats pending busy=%0b, expected 0 pending busy=0", exp_q.size(), o_busy);
    end
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 200 && mon_cnt < target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel1 = 1'(s);
      #1;
      n_tests++;
      if ({o_data, o_mask, o_val, o_last, o_rdy, o_busy, o_drop} !== 13'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b, expected all zero (lanes=%0d)",
                 {o_data, o_mask, o_val, o_last, o_rdy, o_busy, o_drop}, s ? 1 : 4);
      end
    end
    arst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel1 = 1'(s);
      #1;
      n_tests++;
      if (o_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_rdy: got %b, expected 1", o_rdy);
      end
    end
    set_lanes(1'b0);
  endtask

  task automatic test_msb_vector();
    int base, lasts;
    set_lanes(1'b1);
    drv_rdy = 1'b1;
    log_q.delete(); log_cyc.delete();
    base = mon_cnt;
    push_word(16'hA5C3, 4'd0, 1'b1);
    n_tests++;
    if (o_val !== 1'b1 || o_data[0] !== 1'b1 || o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL first_beat_latency: got val=%b data=%b last=%b, expected val=1 data=1 last=0",
               o_val, o_data[0], o_last);
    end
    wait_drain();
    n_tests++;
    if (mon_cnt - base != 16 || ser_hist !== 16'b1010010111000011) begin
      n_fail++;
      $display("FAIL msb_stream: got %0d beats bits=%b, expected 16 beats bits=1010010111000011",
               mon_cnt - base, ser_hist);
    end
    lasts = 0;
    foreach (log_q[i]) if (log_q[i].l) lasts++;
    n_tests++;
    if (lasts != 1 || log_q.size() != 16 || log_q[15].l !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_last: got %0d last flags over %0d beats, expected 1 on beat 16", lasts, log_q.size());
    end
  endtask

  task automatic test_lsb_vector();
    set_lanes(1'b0);
    drv_rdy = 1'b1;
    log_q.delete(); log_cyc.delete();
    push_word(16'h1234, 4'd6, 1'b0);
    wait_drain();
    n_tests++;
    if (log_q.size() != 2 || log_q[0] !== beat_t'({4'b0100, 4'b1111, 1'b0})
        || log_q[1] !== beat_t'({4'b0011, 4'b0011, 1'b1})) begin
      n_fail++;
      $display("FAIL lsb_vector: got %0d beats, expected beats 0100/1111/0 and 0011/0011/1", log_q.size());
    end
  endtask

  task automatic test_short_drop();
    int base, base_drop;
    set_lanes(1'b0);
    drv_rdy = 1'b1;
    base = mon_cnt;
    base_drop = drop_cnt;
    push_word(16'hFFFF, 4'd2, 1'b1);
    n_tests++;
    if (o_drop !== 1'b1 || o_busy !== 1'b0 || o_val !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: got drop=%b busy=%b val=%b, expected 1 0 0", o_drop, o_busy, o_val);
    end
    @(posedge clk); #1;
    n_tests++;
    if (o_drop !== 1'b0 || o_busy !== 1'b0 || o_val !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_width: got drop=%b busy=%b val=%b, expected 0 0 0", o_drop, o_busy, o_val);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (drop_cnt - base_drop != 1 || mon_cnt != base) begin
      n_fail++;
      $display("FAIL drop_count: got %0d drops %0d beats, expected 1 drop 0 beats",
               drop_cnt - base_drop, mon_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ma, mb;
    int total;
    set_lanes(1'b1);
    drv_rdy = 1'b1;
    log_q.delete(); log_cyc.delete();
    ma = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(3, 15));
    mb = 4'($urandom_range(3, 15));
    total = ((ma == 0) ? 16 : int'(ma)) + int'(mb);
    push_word(16'($urandom), ma, 1'($urandom));
    push_word(16'($urandom), mb, 1'($urandom));
    n_tests++;
    if (o_rdy !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_buffer_full: got rdy=%b busy=%b, expected rdy=0 busy=1", o_rdy, o_busy);
    end
    wait_drain();
    n_tests++;
    if (log_q.size() != total || log_cyc[log_cyc.size()-1] - log_cyc[0] != total - 1) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: got %0d beats over %0d cycles, expected %0d beats over %0d cycles",
               log_q.size(), log_cyc[log_cyc.size()-1] - log_cyc[0] + 1, total, total);
    end
    n_tests++;
    if (o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_rdy_return: got %b, expected 1", o_rdy);
    end
  endtask

  task automatic test_stall();
    int base;
    logic [9:0] snap;
    set_lanes(1'b1);
    drv_rdy = 1'b1;
    base = mon_cnt;
    push_word(16'($urandom), 4'd0, 1'($urandom));
    wait_beats(base + 4);
    drv_rdy = 1'b0;
    snap = {o_val, o_data, o_mask, o_last};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({o_val, o_data, o_mask, o_last} !== snap) begin
        n_fail++;
        $display("FAIL stall_beat5: got %b, expected %b (stall cycle %0d)",
                 {o_val, o_data, o_mask, o_last}, snap, k + 1);
      end
    end
    drv_rdy = 1'b1;
    wait_drain();
    n_tests++;
    if (mon_cnt - base != 16) begin
      n_fail++;
      $display("FAIL stall_count: got %0d beats, expected 16", mon_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    set_lanes(1'b1);
    drv_rdy = 1'b1;
    base = mon_cnt;
    push_word(16'($urandom), 4'd0, 1'b1);
    push_word(16'($urandom), 4'd0, 1'b0);
    wait_beats(base + 6);
    arst_n = 1'b0;
    #2;
    n_tests++;
    if ({o_data, o_mask, o_val, o_last, o_rdy, o_busy, o_drop} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b, expected all zero",
               {o_data, o_mask, o_val, o_last, o_rdy, o_busy, o_drop});
    end
    exp_q.delete();
    @(posedge clk); #1;
    arst_n = 1'b1;
    base = mon_cnt;
    repeat (40) @(posedge clk);
    #1;
    n_tests++;
    if (mon_cnt != base || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %0d beats busy=%b rdy=%b, expected 0 beats busy=0 rdy=1",
               mon_cnt - base, o_busy, o_rdy);
    end
  endtask

  task automatic test_random();
    int base_drop, base_exp;
    bit stop;
    base_drop = drop_cnt;
    base_exp = exp_drop;
    for (int round = 0; round < 4; round++) begin
      set_lanes(1'(round % 2));
      stop = 1'b0;
      fork
        begin
          for (int n = 0; n < 12; n++)
            push_word(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            drv_rdy = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
          end
        end
      join
      drv_rdy = 1'b1;
      wait_drain();
    end
    n_tests++;
    if (drop_cnt - base_drop != exp_drop - base_exp) begin
      n_fail++;
      $display("FAIL random_drops: got %0d drop pulses, expected %0d",
               drop_cnt - base_drop, exp_drop - base_exp);
    end
  endtask

  initial begin
    test_reset();
    test_msb_vector();
    test_lsb_vector();
    test_short_drop();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 Parameter DATA_W, default 16, parallel word width; SHALL be >= 2.
REQ-002 Parameter LANES, default 1, serial bits per output beat; SHALL divide DATA_W evenly.
REQ-003 Parameter MOD_W, default $clog2(DATA_W), width of the length field.
REQ-004 Parameter MIN_LEN, default 3, minimum word length in bits; shorter words are dropped.
REQ-005 clk_i  in  1  single clock; all state changes on posedge.
REQ-006 arst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 data_i  in  DATA_W  parallel word.
REQ-008 data_mod_i  in  MOD_W  word length: 0 = DATA_W bits, else the value in bits.
REQ-009 msb_first_i  in  1  bit order of the word: 1 = MSB first, 0 = LSB first.
REQ-010 data_val_i  in  1  input word valid.
REQ-011 data_rdy_o  out  1  input ready; a word is accepted when data_val_i && data_rdy_o at posedge.
REQ-012 ser_data_o  out  LANES  serial beat; lane 0 carries the earliest bit of the beat.
REQ-013 ser_mask_o  out  LANES  per-lane valid mask for the current beat.
REQ-014 ser_data_val_o  out  1  beat valid.
REQ-015 ser_rdy_i  in  1  downstream ready; a beat is consumed when ser_data_val_o && ser_rdy_i at posedge.
REQ-016 ser_last_o  out  1  current beat is the final beat of its word.
REQ-017 busy_o  out  1  shifter or skid buffer holds a word.
REQ-018 drop_o  out  1  single-cycle pulse, a short word was discarded.

Function
REQ-019 Word length len = DATA_W if data_mod_i == 0, else data_mod_i; msb_first_i and len SHALL be captured at acceptance, and later input changes SHALL NOT affect that word.
REQ-020 Stream bit s (s = 0 .. len-1) SHALL be data_i[DATA_W-1-s] when MSB-first, and data_i[s] when LSB-first.
REQ-021 Beat count = ceil(len/LANES); in beat b, lane j SHALL carry stream bit b*LANES+j, with ser_mask_o[j] = 1 iff b*LANES+j < len; unmasked lanes SHALL drive 0.
REQ-022 Storage SHALL be one shifter plus one skid-buffer entry; data_rdy_o SHALL be 1 iff the skid buffer is empty, and SHALL depend only on registered state.
REQ-023 An accepted word with len >= MIN_LEN SHALL load the shifter directly if the shifter is idle, or if its final beat is consumed in the same cycle and the buffer is empty; otherwise it SHALL go to the buffer.
REQ-024 The first beat SHALL be valid on the cycle after the word loads into the shifter; input-to-first-beat latency is therefore 1 cycle when the shifter is free.
REQ-025 When the final beat is consumed and the buffer is full, the buffer word SHALL load into the shifter and the buffer SHALL free in the same cycle; there SHALL be no bubble between words.
REQ-026 While ser_data_val_o && !ser_rdy_i, ser_data_o, ser_mask_o and ser_last_o SHALL hold stable.
REQ-027 An accepted word with len < MIN_LEN SHALL be consumed with no beats, SHALL NOT occupy storage, and SHALL pulse drop_o on the following cycle.
REQ-028 The FSM SHALL have two states. IDLE -> SHIFT on shifter load. SHIFT -> IDLE on final-beat consume with no buffered or simultaneously accepted word. Otherwise the FSM SHALL stay in SHIFT.
REQ-029 ser_data_val_o SHALL be 1 only in SHIFT; busy_o SHALL equal (state == SHIFT) || buffer full.
REQ-030 The beat counter SHALL count to ceil(DATA_W/LANES)-1 with no wrap; illegal data_mod_i > DATA_W SHALL be treated as DATA_W.

Reset
REQ-031 While arst_n_i == 0: all outputs 0 (including data_rdy_o), state IDLE, buffer empty, counters 0.
REQ-032 After release, data_rdy_o SHALL be 1 from the first posedge.
REQ-033 Reset mid-word SHALL abort the word and the buffered word; no beat of either SHALL appear after release.

Verification
REQ-034 DATA_W=16, LANES=1, MSB-first, 0xA5C3, mod 0 -> 16 beats 1010010111000011, ser_last_o on beat 16 only, first beat 1 cycle after accept.
REQ-035 DATA_W=16, LANES=4, LSB-first, 0x1234, mod 6 -> beat0 data 4'b0100 mask 4'b1111; beat1 data 4'b0011 mask 4'b0011 with ser_last_o.
REQ-036 mod 2 with MIN_LEN=3 -> accepted, no ser_data_val_o, drop_o high for exactly 1 cycle, busy_o stays 0.
REQ-037 Two words presented back-to-back with ser_rdy_i=1 -> data_rdy_o drops while the buffer is full, zero idle cycles between the last beat of word 1 and the first beat of word 2.
REQ-038 ser_rdy_i held low for 3 cycles on beat 5 -> beat 5 outputs stable for 4 cycles, no beat lost or duplicated.
REQ-039 arst_n_i pulsed low on beat 7 with a word buffered -> all outputs 0, and after release there are no beats until a new word is accepted.
